// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO blocks: arbiter state encoding and a
// constant-evaluable ceil(log2) helper for sizing counters and indices.
package fifo_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester strictly
// after 'last' in ascending order with wrap, as a one-hot vector.
module rr_pick
   import fifo_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]        req,
   input  logic [clog2(NREQ)-1:0] last,
   output logic [NREQ-1:0]        pick,
   output logic                   valid
);

   localparam int LW = clog2(NREQ);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      pick  = '0;
      valid = 1'b0;
      // Indices above 'last' come first, then the wrapped range 0..last.
      for (int i = 0; i < NREQ; i++) begin
         if (!valid && req[i] && (LW'(i) > last)) begin
            pick[i] = 1'b1;
            valid   = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!valid && req[i] && (LW'(i) <= last)) begin
            pick[i] = 1'b1;
            valid   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing the async FIFO read port among NREQ consumers;
// grants bounded bursts and steers returned data with per-consumer valids.
module fifo_rd_arbiter
   import fifo_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DW       = 8,
   parameter int MAXBURST = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            fifo_empty,
   input  logic [DW-1:0]   fifo_rdata,
   output logic            fifo_re,
   output logic [NREQ-1:0] grant,
   output logic [NREQ-1:0] rvalid,
   output logic [DW-1:0]   rdata,
   output logic            busy
);

   localparam int              LW       = clog2(NREQ);
   localparam int              CW       = clog2(MAXBURST + 1);
   localparam logic [CW-1:0]   CNT_MAX  = CW'(MAXBURST);
   localparam logic [LW-1:0]   LAST_RST = LW'(NREQ - 1);

   arb_state_e      state_q;
   logic [NREQ-1:0] grant_q;
   logic [NREQ-1:0] rvalid_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [LW-1:0]   last_q;
   logic [LW-1:0]   owner;
   logic            owner_req;
   logic [NREQ-1:0] pick;
   logic            pick_valid;

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .req   (req),
      .last  (last_q),
      .pick  (pick),
      .valid (pick_valid)
   );

   always_comb begin
      owner = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_q[i]) owner = LW'(i);
      end
   end

   assign owner_req = |(req & grant_q);
   assign cnt_d     = cnt_q + CW'(1);
   assign fifo_re   = (state_q == ST_BURST) & owner_req & ~fifo_empty & (cnt_q < CNT_MAX);

   // NOTE: state is registered with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rvalid_q <= '0;
         cnt_q    <= '0;
         last_q   <= LAST_RST;
      end else begin
         // The final read of a burst still reaches its owner after grant drops.
         rvalid_q <= fifo_re ? grant_q : '0;
         case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  state_q <= ST_BURST;
                  grant_q <= pick;
                  cnt_q   <= '0;
               end
            end
            ST_BURST: begin
               if (!owner_req || (fifo_re && (cnt_d == CNT_MAX))) begin
                  state_q <= ST_IDLE;
                  grant_q <= '0;
                  cnt_q   <= '0;
                  last_q  <= owner;
               end else if (fifo_re) begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign grant  = grant_q;
   assign rvalid = rvalid_q;
   assign rdata  = fifo_rdata;
   assign busy   = (state_q == ST_BURST);

endmodule
